// File: rtl/cmd_entry_fsm.sv
`timescale 1ns/1ps
// cmd_entry_fsm
// Per-master command entry stage feeding master_module. Push-button presses
// step through slave / address / burst (+rw) / data entry from the switch
// array. A confirm press arms the command, and the block issues a single-cycle
// read or write strobe once the paired master is idle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   next_btn            advance/confirm button (active-high, asynchronous)
//   cancel_btn          abort-entry button (active-high, asynchronous)
//   switch_array[11:0]  field value entry (quasi-static, sampled directly)
//   rw_switch           1 = write, 0 = read (latched with the burst field)
//   master_busy         busy flag from the paired master
//   read, write         one-cycle command strobes
//   data, address, slave, burst_num   latched command fields
//   entry_state         current FSM state encoding (for LEDs)
//   cmd_pending         high from confirm until the master returns idle
//
// Optional feature macro: CMD_AUTO_INCR_EN
//   When defined, a completed command advances address by burst_num and
//   re-enters S_DATA (write) or S_ARMED (read) for fast sequential bursts.
module cmd_entry_fsm #(
    parameter int SLAVE_LEN       = 2,
    parameter int ADDR_LEN        = 12,
    parameter int DATA_LEN        = 8,
    parameter int BURST_LEN       = 12,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 next_btn,
    input  logic                 cancel_btn,
    input  logic [11:0]          switch_array,
    input  logic                 rw_switch,
    input  logic                 master_busy,
    output logic                 read,
    output logic                 write,
    output logic [DATA_LEN-1:0]  data,
    output logic [ADDR_LEN:0]    address,
    output logic [SLAVE_LEN-1:0] slave,
    output logic [BURST_LEN:0]   burst_num,
    output logic [2:0]           entry_state,
    output logic                 cmd_pending
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int BW = BURST_LEN + 1;

    typedef enum logic [2:0] {
        S_SLAVE = 3'd0,
        S_ADDR  = 3'd1,
        S_BURST = 3'd2,
        S_DATA  = 3'd3,
        S_ARMED = 3'd4,
        S_ISSUE = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    // Button conditioning: index 0 = next, index 1 = cancel.
    logic [1:0]       btn_raw;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       db_lvl;
    logic [1:0]       btn_evt;
    logic [CNT_W-1:0] db_cnt [2];

    logic next_evt;
    logic cancel_evt;

    assign btn_raw    = {cancel_btn, next_btn};
    assign next_evt   = btn_evt[0];
    assign cancel_evt = btn_evt[1];

    // Two-flop synchroniser, then a level debouncer: the accepted level only
    // flips after DEBOUNCE_CYCLES consecutive differing samples, and an event
    // fires only on an accepted rising level, so a held button yields one event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_lvl  <= '0;
            btn_evt <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                btn_evt[i] <= 1'b0;
                if (sync_p1[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i]  <= sync_p1[i];
                    db_cnt[i]  <= '0;
                    btn_evt[i] <= sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    state_t state, state_nxt;
    logic   rw_lat;
    logic   busy_seen;
    logic [4:0] tmo_cnt;

    logic cap_slave, cap_addr, cap_burst, cap_data;
    logic set_pend, clr_pend, rd_nxt, wr_nxt, cmd_done;

    logic [BURST_LEN-1:0] sw_burst;
    logic [BURST_LEN:0]   burst_cap;

    // A zero burst is meaningless to the master, so it is stored as 1.
    assign sw_burst  = BURST_LEN'(switch_array);
    assign burst_cap = (sw_burst == '0) ? BW'(1) : {1'b0, sw_burst};

`ifdef CMD_AUTO_INCR_EN
    logic [ADDR_LEN-1:0] addr_inc;
    assign addr_inc = address[ADDR_LEN-1:0] + ADDR_LEN'(burst_num);
`endif

    always_comb begin
        state_nxt = state;
        cap_slave = 1'b0;
        cap_addr  = 1'b0;
        cap_burst = 1'b0;
        cap_data  = 1'b0;
        set_pend  = 1'b0;
        clr_pend  = 1'b0;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        cmd_done  = 1'b0;

        case (state)
            S_SLAVE: if (next_evt) begin cap_slave = 1'b1; state_nxt = S_ADDR;  end
            S_ADDR:  if (next_evt) begin cap_addr  = 1'b1; state_nxt = S_BURST; end
            S_BURST: if (next_evt) begin
                cap_burst = 1'b1;
                state_nxt = rw_switch ? S_DATA : S_ARMED;
            end
            S_DATA:  if (next_evt) begin cap_data  = 1'b1; state_nxt = S_ARMED; end
            S_ARMED: if (next_evt) begin set_pend  = 1'b1; state_nxt = S_ISSUE; end
            S_ISSUE: if (!master_busy) begin
                rd_nxt    = !rw_lat;
                wr_nxt    = rw_lat;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Done on busy rise-then-fall, or if busy never rose within
                // 16 cycles of the strobe.
                if (!master_busy && (busy_seen || tmo_cnt == 5'd15)) cmd_done = 1'b1;
            end
            default: state_nxt = S_SLAVE;
        endcase

        if (cmd_done) begin
            clr_pend = 1'b1;
`ifdef CMD_AUTO_INCR_EN
            state_nxt = rw_lat ? S_DATA : S_ARMED;
`else
            state_nxt = S_SLAVE;
`endif
        end

        // Cancel wins over a simultaneous next; ignored once the command issues.
        if (cancel_evt && (state <= S_ARMED)) begin
            state_nxt = S_SLAVE;
            cap_slave = 1'b0;
            cap_addr  = 1'b0;
            cap_burst = 1'b0;
            cap_data  = 1'b0;
            set_pend  = 1'b0;
            clr_pend  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_SLAVE;
            read        <= 1'b0;
            write       <= 1'b0;
            data        <= '0;
            address     <= '0;
            slave       <= '0;
            burst_num   <= '0;
            rw_lat      <= 1'b0;
            cmd_pending <= 1'b0;
            busy_seen   <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state <= state_nxt;
            read  <= rd_nxt;
            write <= wr_nxt;
            if (cap_slave) slave   <= SLAVE_LEN'(switch_array);
            if (cap_addr)  address <= {1'b0, ADDR_LEN'(switch_array)};
            if (cap_burst) begin
                burst_num <= burst_cap;
                rw_lat    <= rw_switch;
            end
            if (cap_data)  data <= DATA_LEN'(switch_array);
            if (set_pend)      cmd_pending <= 1'b1;
            else if (clr_pend) cmd_pending <= 1'b0;
            if (rd_nxt || wr_nxt) begin
                busy_seen <= 1'b0;
                tmo_cnt   <= '0;
            end else if (state == S_WAIT) begin
                if (master_busy)       busy_seen <= 1'b1;
                if (tmo_cnt != 5'd31)  tmo_cnt   <= tmo_cnt + 5'd1;
            end
`ifdef CMD_AUTO_INCR_EN
            if (cmd_done) address <= {1'b0, addr_inc};
`endif
        end
    end

    assign entry_state = state;

endmodule

// File: doc/cmd_entry_fsm.md
Name: cmd_entry_fsm

Overview:
Per-master command entry stage that sits directly upstream of master_module. It turns debounced push-button presses and the 12-bit switch array into one complete bus command: slave select, address, burst length, write data and a read/write strobe. One instance serves each master. It holds the latched fields stable and issues a single-cycle read or write pulse when the master is idle.

Parameters:
SLAVE_LEN, 2, width of slave select field
ADDR_LEN, 12, address field; output address is ADDR_LEN+1 bits
DATA_LEN, 8, write data width (must be <= 12)
BURST_LEN, 12, burst field; output burst_num is BURST_LEN+1 bits
DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a button level change

Ports:
clk  in  1  system clock (scaled clock domain)
rst  in  1  asynchronous reset, active-low
next_btn  in  1  advance/confirm button, active-high (already inverted), asynchronous
cancel_btn  in  1  abort-entry button, active-high, asynchronous
switch_array  in  12  field value entry
rw_switch  in  1  1 = write, 0 = read
master_busy  in  1  busy flag from the paired master
read  out  1  one-cycle read strobe to master
write  out  1  one-cycle write strobe to master
data  out  DATA_LEN  latched write data
address  out  ADDR_LEN+1  latched address
slave  out  SLAVE_LEN  latched slave select
burst_num  out  BURST_LEN+1  latched burst length
entry_state  out  3  current FSM state encoding, for LEDs
cmd_pending  out  1  high from confirm until the master returns idle

Behaviour:
- Reset (rst=0, async) clears all outputs to 0, sets the FSM to S_SLAVE, and clears the synchronisers and debounce counters. Leaving reset is synchronous to clk.
- Each button passes through a 2-flop synchroniser and then a debouncer.
  - A press event is one clk pulse, emitted after DEBOUNCE_CYCLES consecutive synchronised highs.
  - The next event on that button requires DEBOUNCE_CYCLES consecutive lows first. A held button gives exactly one event.
  - Minimum press-to-event latency is 2 + DEBOUNCE_CYCLES cycles.
- State encoding: S_SLAVE=0, S_ADDR=1, S_BURST=2, S_DATA=3, S_ARMED=4, S_ISSUE=5, S_WAIT=6.
- S_SLAVE: on next_evt, slave <= switch_array[SLAVE_LEN-1:0]; go to S_ADDR.
- S_ADDR: on next_evt, address <= {0, switch_array[ADDR_LEN-1:0]}. Bit ADDR_LEN is always 0; zero-extend if ADDR_LEN > 12. Go to S_BURST.
- S_BURST: on next_evt:
  - burst_num <= zero-extended switch_array[BURST_LEN-1:0]; an entered 0 is stored as 1.
  - rw_switch is latched into an internal rw_lat.
  - If rw_lat=1, go to S_DATA; otherwise go to S_ARMED.
- S_DATA: on next_evt, data <= switch_array[DATA_LEN-1:0]; go to S_ARMED.
- S_ARMED: on next_evt, set cmd_pending=1 and go to S_ISSUE.
- S_ISSUE: hold while master_busy=1. When master_busy=0, pulse write (rw_lat=1) or read (rw_lat=0) for exactly 1 cycle, then go to S_WAIT.
  - read and write are never high together.
- S_WAIT: wait for master_busy to rise, then fall. Then clear cmd_pending and go to S_SLAVE.
  - If master_busy has not risen within 16 cycles of the strobe, treat the command as done anyway. This timeout counter is 5 bits.
- cancel_evt in S_SLAVE..S_ARMED returns to S_SLAVE next cycle. Latched fields are retained and cmd_pending is cleared.
- cancel_evt in S_ISSUE or S_WAIT is ignored.
- next_evt and cancel_evt in the same cycle: cancel wins.
- next_evt in S_ISSUE or S_WAIT is discarded, not queued.
- data, address, slave and burst_num change only on their own capture cycle and are otherwise stable, including across the strobe.
- switch_array is sampled directly (quasi-static). It is not synchronised.

Optional Feature:
CMD_AUTO_INCR_EN
- Defined, after S_WAIT completes:
  - address[ADDR_LEN-1:0] <= address[ADDR_LEN-1:0] + burst_num, wrapping modulo 2^ADDR_LEN; bit ADDR_LEN stays 0.
  - The FSM returns to S_DATA for a write or S_ARMED for a read, for fast sequential bursts.
  - cancel_evt still returns to S_SLAVE.
- Undefined: return to S_SLAVE and address is unchanged.

Test Plan:
- Reset mid-entry: rst=0 in S_BURST with fields nonzero -> all outputs 0, entry_state=0 in the same cycle (async).
- Write entry: next presses with switches 0x002, 0x0A5, 0x004 (rw=1), 0x03C; master_busy=0; confirm -> write pulses 1 cycle with slave=2, address=0x0A5, burst_num=4, data=0x3C; read never asserts.
- Read entry with burst 0: switches 0x001, 0x7FF, 0x000 (rw=0), confirm -> burst_num=1, S_DATA skipped, read pulses 1 cycle.
- Busy hold: master_busy=1 at confirm -> no strobe until master_busy falls, then strobe on the next cycle; cmd_pending stays 1 until busy rise and fall.
- Debounce/cancel: next_btn glitch of 3 cycles -> no advance; held for 100 cycles -> exactly one advance; next and cancel events in the same cycle in S_ADDR -> entry_state=0.
- CMD_AUTO_INCR_EN: address=0xFFE, burst 4, write completes -> address=0x002, entry_state=3 (S_DATA).
